// File: rtl/ddr2_cmd_sequencer.sv
// Table-driven command injector for the ddr2_controller host port: replays loaded
// entries with FIFO flow control, streams block-write data beats and can loop.
module ddr2_cmd_sequencer #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned AW       = 25,
  parameter int unsigned DW       = 16,
  parameter int unsigned WAIT_W   = 8,
  parameter int unsigned FILL_W   = 7,
  parameter int unsigned FILL_MAX = 63
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          LD_EN,
  input  logic [$clog2(DEPTH)-1:0]      LD_ADDR,
  input  logic [WAIT_W+9+AW+DW-1:0]     LD_WORD,
  input  logic [$clog2(DEPTH):0]        NUM_ENT,
  input  logic                          START,
  input  logic                          ABORT,
  input  logic                          LOOP_EN,
  input  logic                          NOTFULL,
  input  logic [FILL_W-1:0]             FILLCOUNT,
  output logic [2:0]                    CMD,
  output logic [1:0]                    SZ,
  output logic [2:0]                    OP,
  output logic [AW-1:0]                 ADDR,
  output logic [DW-1:0]                 DIN,
  output logic                          FETCHING,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          ERR,
  output logic [15:0]                   ISSUE_CNT
);

  localparam int unsigned LAW = $clog2(DEPTH);

  typedef struct packed {
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        cmd;
    logic [1:0]        sz;
    logic [2:0]        op;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     data;
    logic              fetching;
  } entry_t;

  typedef struct packed {
    logic [2:0]    cmd;
    logic [1:0]    sz;
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          fetching;
  } out_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_PRESENT, S_BURST, S_FIN
  } state_t;

  entry_t          pat_q [DEPTH];
  state_t          state_q, state_d;
  logic [LAW:0]    idx_q, idx_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [5:0]      beats_q, beats_d;
  out_t            out_q, out_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            abort_now, fill_ok, consume;
  logic            load_req, bnext_req, fin_req;
  logic [LAW:0]    load_idx, bnext_idx;
  logic [5:0]      bnext_beats;
  entry_t          ent_ld;

  // NOP drives nothing; address-side fields for any real command; DIN only for data-carrying commands
  function automatic out_t present(input entry_t e);
    out_t o;
    o = '0;
    if (e.cmd != 3'd0) begin
      o.cmd      = e.cmd;
      o.sz       = e.sz;
      o.op       = e.op;
      o.addr     = e.addr;
      o.fetching = e.fetching;
    end
    if (e.cmd inside {3'd2, 3'd4, 3'd5, 3'd6}) o.din = e.data;
    return o;
  endfunction

  assign abort_now = ABORT && (state_q inside {S_LOAD, S_WAIT, S_PRESENT, S_BURST});
  assign fill_ok   = (FILLCOUNT <= FILL_W'(FILL_MAX));

  always_comb begin
    case (out_q.cmd)
      3'd0, 3'd7: consume = 1'b1;
      3'd1, 3'd3: consume = NOTFULL;
      default:    consume = NOTFULL && fill_ok;
    endcase
  end

  // The case only requests a load / next-beat / finish; those shared actions are
  // resolved afterwards so a consume can present the next entry without a bubble.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    beats_d     = beats_q;
    out_d       = out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    cnt_d       = cnt_q;
    load_req    = 1'b0;
    load_idx    = idx_q;
    bnext_req   = 1'b0;
    bnext_idx   = idx_q;
    bnext_beats = beats_q;
    fin_req     = 1'b0;
    ent_ld      = '0;

    if (abort_now) begin
      fin_req = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_d = S_LOAD;
            idx_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            out_d   = '0;
          end
        end
        S_LOAD: load_req = 1'b1;
        S_WAIT: begin
          if (wcnt_q == WAIT_W'(1)) begin
            state_d = S_PRESENT;
            out_d   = present(pat_q[idx_q[LAW-1:0]]);
          end else begin
            wcnt_d = wcnt_q - 1'b1;
          end
        end
        S_PRESENT: begin
          if (consume) begin
            if (out_q.cmd != 3'd0) cnt_d = cnt_q + 16'd1;
            if (out_q.cmd == 3'd4) begin
              bnext_req   = 1'b1;
              bnext_idx   = idx_q + 1'b1;
              bnext_beats = {1'b0, out_q.sz, 3'b111};
            end else begin
              load_req = 1'b1;
              load_idx = idx_q + 1'b1;
            end
          end
        end
        S_BURST: begin
          if (fill_ok) begin
            if (beats_q == 6'd1) begin
              load_req = 1'b1;
              load_idx = idx_q + 1'b1;
            end else begin
              bnext_req   = 1'b1;
              bnext_idx   = idx_q + 1'b1;
              bnext_beats = beats_q - 6'd1;
            end
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          out_d   = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (bnext_req) begin
      idx_d = bnext_idx;
      if (bnext_idx >= NUM_ENT) begin
        err_d   = 1'b1;
        fin_req = 1'b1;
      end else begin
        state_d   = S_BURST;
        beats_d   = bnext_beats;
        out_d     = '0;
        out_d.din = pat_q[bnext_idx[LAW-1:0]].data;
      end
    end

    if (load_req) begin
      idx_d = load_idx;
      if (load_idx >= NUM_ENT && !(LOOP_EN && NUM_ENT != '0)) begin
        fin_req = 1'b1;
      end else begin
        if (load_idx >= NUM_ENT) idx_d = '0;
        ent_ld = pat_q[idx_d[LAW-1:0]];
        if (ent_ld.wait_cnt != '0) begin
          state_d = S_WAIT;
          wcnt_d  = ent_ld.wait_cnt;
          out_d   = '0;
        end else begin
          state_d = S_PRESENT;
          out_d   = present(ent_ld);
        end
      end
    end

    if (fin_req) begin
      state_d = S_FIN;
      out_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      beats_q <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      beats_q <= beats_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (LD_EN && !busy_q) pat_q[LD_ADDR] <= entry_t'(LD_WORD);
  end

  assign CMD       = out_q.cmd;
  assign SZ        = out_q.sz;
  assign OP        = out_q.op;
  assign ADDR      = out_q.addr;
  assign DIN       = out_q.din;
  assign FETCHING  = out_q.fetching;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign ISSUE_CNT = cnt_q;

endmodule

// File: tb/tb_ddr2_cmd_sequencer.sv
// Directed bench for ddr2_cmd_sequencer: hand-computed sequences for replay,
// wait, flow control, bursts, overrun error, looping, abort and reset.
module tb_ddr2_cmd_sequencer;

  localparam int unsigned E = 58;

  logic          clk = 1'b0;
  logic          reset, ld_en, start, abort, loop_en, notfull;
  logic [5:0]    ld_addr;
  logic [E-1:0]  ld_word;
  logic [6:0]    num_ent;
  logic [6:0]    fillcount;
  logic [2:0]    cmd, op;
  logic [1:0]    sz;
  logic [24:0]   addr;
  logic [15:0]   din, issue_cnt;
  logic          fetching, busy, done, err;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  ddr2_cmd_sequencer #(.DEPTH(64), .AW(25), .DW(16), .WAIT_W(8), .FILL_W(7), .FILL_MAX(63)) dut (
    .CLK(clk), .RESET(reset), .LD_EN(ld_en), .LD_ADDR(ld_addr), .LD_WORD(ld_word),
    .NUM_ENT(num_ent), .START(start), .ABORT(abort), .LOOP_EN(loop_en),
    .NOTFULL(notfull), .FILLCOUNT(fillcount), .CMD(cmd), .SZ(sz), .OP(op),
    .ADDR(addr), .DIN(din), .FETCHING(fetching), .BUSY(busy), .DONE(done),
    .ERR(err), .ISSUE_CNT(issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [E-1:0] ent(input logic [7:0] w, input logic [2:0] c,
                                       input logic [1:0] s, input logic [2:0] o,
                                       input logic [24:0] a, input logic [15:0] d,
                                       input logic f);
    return {w, c, s, o, a, d, f};
  endfunction

  task automatic ld(input int unsigned i, input logic [E-1:0] w);
    ld_en   = 1'b1;
    ld_addr = 6'(i);
    ld_word = w;
    step();
    ld_en   = 1'b0;
  endtask

  // START pulse, one LOAD cycle, then the first entry is visible
  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_cmd", 32'(cmd), 32'd0);
    step();
  endtask

  task automatic chk_fin(input string tag, input logic [15:0] exp_cnt);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cmd"}, 32'(cmd), 32'd0);
    chk({tag, "_cnt"}, 32'(issue_cnt), 32'(exp_cnt));
    step();
    chk({tag, "_done_end"}, 32'(done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ld_en = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
    notfull = 1'b1; ld_addr = '0; ld_word = '0; num_ent = '0; fillcount = '0;
    step(); step();
    reset = 1'b0;

    // reset state
    chk("rst_ctl", 32'({cmd, sz, op, fetching, busy, done, err}), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_cnt", 32'(issue_cnt), 32'd0);

    // back-to-back replay
    ld(0, ent(8'd0, 3'd2, 2'd0, 3'd0, 25'h1BABAFE, 16'hCAFE, 1'b0));
    ld(1, ent(8'd0, 3'd1, 2'd2, 3'd5, 25'h0000100, 16'h1111, 1'b1));
    ld(2, ent(8'd0, 3'd0, 2'd3, 3'd7, 25'h0000200, 16'h2222, 1'b1));
    num_ent = 7'd3;
    start_run();
    chk("t1_cmd0", 32'(cmd), 32'd2);
    chk("t1_addr0", 32'(addr), 32'h1BABAFE);
    chk("t1_din0", 32'(din), 32'hCAFE);
    step();
    chk("t1_cmd1", 32'(cmd), 32'd1);
    chk("t1_rd_fields", 32'({sz, op, fetching}), 32'({2'd2, 3'd5, 1'b1}));
    chk("t1_addr1", 32'(addr), 32'h100);
    chk("t1_din1_zero", 32'(din), 32'd0);
    step();
    chk("t1_nop_fields", 32'({cmd, sz, op, fetching}), 32'd0);
    chk("t1_nop_busy", 32'(busy), 32'd1);
    step();
    chk_fin("t1", 16'd2);

    // wait count of 10
    ld(0, ent(8'd10, 3'd2, 2'd0, 3'd0, 25'h00ABCDE, 16'h5A5A, 1'b0));
    num_ent = 7'd1;
    start_run();
    for (int i = 0; i < 10; i++) begin
      chk("t2_wait_cmd", 32'(cmd), 32'd0);
      chk("t2_wait_busy", 32'(busy), 32'd1);
      step();
    end
    chk("t2_cmd", 32'(cmd), 32'd2);
    chk("t2_addr", 32'(addr), 32'h0ABCDE);
    chk("t2_din", 32'(din), 32'h5A5A);
    step();
    chk_fin("t2", 16'd1);

    // flow control on NOTFULL and FILLCOUNT
    ld(0, ent(8'd0, 3'd1, 2'd0, 3'd0, 25'h0000777, 16'h1234, 1'b0));
    ld(1, ent(8'd0, 3'd2, 2'd0, 3'd0, 25'h0000888, 16'hBEEF, 1'b0));
    ld(2, ent(8'd0, 3'd1, 2'd0, 3'd0, 25'h0000999, 16'h0000, 1'b0));
    num_ent = 7'd3;
    notfull = 1'b0;
    start_run();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_cmd", 32'(cmd), 32'd1);
      chk("t3_hold_addr", 32'(addr), 32'h777);
      step();
    end
    chk("t3_hold_last", 32'(cmd), 32'd1);
    notfull = 1'b1;
    step();
    chk("t3_wr_cmd", 32'(cmd), 32'd2);
    fillcount = 7'd64;
    step();
    step();
    chk("t3_fill_stall_cmd", 32'(cmd), 32'd2);
    chk("t3_fill_stall_din", 32'(din), 32'hBEEF);
    fillcount = 7'd63;
    step();
    chk("t3_fill63_cmd", 32'(cmd), 32'd1);
    chk("t3_fill63_addr", 32'(addr), 32'h999);
    fillcount = 7'd64;
    step();
    chk_fin("t3", 16'd3);
    fillcount = 7'd0;

    // block write: SZ=1 gives 16 beats, 3-cycle stall mid-burst
    ld(0, ent(8'd0, 3'd4, 2'd1, 3'd2, 25'h0004000, 16'hD000, 1'b0));
    for (int i = 1; i < 16; i++)
      ld(i, ent(8'd5, 3'd3, 2'd2, 3'd1, 25'h00001FF, 16'hD000 + 16'(i), 1'b1));
    ld(16, ent(8'd0, 3'd1, 2'd0, 3'd0, 25'h0000042, 16'h0000, 1'b0));
    num_ent = 7'd17;
    start_run();
    chk("t4_bw_cmd", 32'(cmd), 32'd4);
    chk("t4_bw_fields", 32'({sz, op}), 32'({2'd1, 3'd2}));
    chk("t4_bw_addr", 32'(addr), 32'h4000);
    chk("t4_bw_din", 32'(din), 32'hD000);
    step();
    for (int k = 1; k < 16; k++) begin
      chk("t4_beat_din", 32'(din), 32'(16'hD000 + 16'(k)));
      chk("t4_beat_ctl", 32'({cmd, sz, op, fetching}), 32'd0);
      chk("t4_beat_addr", 32'(addr), 32'd0);
      if (k == 7) begin
        fillcount = 7'd64;
        for (int s = 0; s < 3; s++) begin
          step();
          chk("t4_stall_din", 32'(din), 32'hD007);
        end
        fillcount = 7'd0;
      end
      step();
    end
    chk("t4_next_cmd", 32'(cmd), 32'd1);
    chk("t4_next_addr", 32'(addr), 32'h42);
    chk("t4_cnt", 32'(issue_cnt), 32'd1);
    step();
    chk_fin("t4", 16'd2);

    // burst overruns NUM_ENT
    ld(0, ent(8'd0, 3'd4, 2'd3, 3'd0, 25'h0008000, 16'hE000, 1'b0));
    for (int i = 1; i < 10; i++)
      ld(i, ent(8'd0, 3'd0, 2'd0, 3'd0, 25'h0, 16'hE000 + 16'(i), 1'b0));
    num_ent = 7'd10;
    start_run();
    chk("t5_cmd", 32'(cmd), 32'd4);
    for (int i = 0; i < 9; i++) step();
    chk("t5_last_din", 32'(din), 32'hE009);
    chk("t5_err_pre", 32'(err), 32'd0);
    step();
    chk("t5_err", 32'(err), 32'd1);
    chk_fin("t5", 16'd1);
    chk("t5_err_sticky", 32'(err), 32'd1);
    num_ent = 7'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_err_clr", 32'(err), 32'd0);
    chk("t5_empty_cnt", 32'(issue_cnt), 32'd0);
    step();
    chk_fin("t5_empty", 16'd0);

    // looping, dropped load while busy, abort
    ld(0, ent(8'd0, 3'd1, 2'd0, 3'd0, 25'h0000011, 16'h0, 1'b0));
    ld(1, ent(8'd0, 3'd3, 2'd0, 3'd0, 25'h0000022, 16'h0, 1'b0));
    num_ent = 7'd2;
    loop_en = 1'b1;
    start_run();
    chk("t6_e0_cmd", 32'(cmd), 32'd1);
    chk("t6_e0_addr", 32'(addr), 32'h11);
    ld(0, ent(8'd0, 3'd2, 2'd0, 3'd0, 25'h0000055, 16'h5555, 1'b0));
    chk("t6_e1_cmd", 32'(cmd), 32'd3);
    chk("t6_e1_addr", 32'(addr), 32'h22);
    step();
    chk("t6_wrap_cmd", 32'(cmd), 32'd1);
    chk("t6_wrap_addr", 32'(addr), 32'h11);
    step();
    chk("t6_e1b_cmd", 32'(cmd), 32'd3);
    step();
    chk("t6_e0c_cmd", 32'(cmd), 32'd1);
    chk("t6_loop_cnt", 32'(issue_cnt), 32'd4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_fin("t6_abort", 16'd4);

    // reset mid-run, then START coincident with RESET
    start_run();
    step();
    chk("t6_run_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_cmd", 32'(cmd), 32'd0);
    chk("t6_rst_cnt", 32'(issue_cnt), 32'd0);
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    chk("t6_rst_start_busy", 32'(busy), 32'd0);
    step();
    chk("t6_rst_start_idle", 32'({busy, cmd}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
